// File: rtl/register_bank.sv
// Multi-channel register bank: direct or shadowed loads, atomic commit, output pipeline.
// Define REGISTER_BANK_UPDATE_CNT_EN to add the 16-bit update_cnt output.
module register_bank #(
    parameter int               NBITS     = 16,
    parameter int               NCH       = 4,
    parameter int               DEPTH     = 1,
    parameter logic [NBITS-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ce,
    input  logic [NCH*NBITS-1:0] din,
    input  logic                 shadow_mode,
    input  logic                 commit,
    output logic [NCH*NBITS-1:0] dout,
    output logic                 dout_valid,
    output logic [NCH-1:0]       pending
`ifdef REGISTER_BANK_UPDATE_CNT_EN
    ,
    output logic [15:0]          update_cnt
`endif
);

    localparam int W = NCH * NBITS;
    localparam logic [W-1:0] RST_VEC = {NCH{RESET_VAL}};

    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   active_q, active_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic           event_q, event_d;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        event_d   = shadow_mode ? commit : |ce;
        for (int i = 0; i < NCH; i++) begin
            if (ce[i]) begin
                shadow_d[i*NBITS +: NBITS] = din[i*NBITS +: NBITS];
            end
            if (!shadow_mode) begin
                if (ce[i]) begin
                    active_d[i*NBITS +: NBITS] = din[i*NBITS +: NBITS];
                end
            end else if (commit) begin
                // A load coinciding with commit bypasses its stale shadow.
                active_d[i*NBITS +: NBITS] = ce[i] ? din[i*NBITS +: NBITS]
                                                   : shadow_q[i*NBITS +: NBITS];
            end
        end
        if (!shadow_mode || commit) begin
            pending_d = '0;
        end else begin
            pending_d = pending_q | ce;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= RST_VEC;
            active_q  <= RST_VEC;
            pending_q <= '0;
            event_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            event_q   <= event_d;
        end
    end

    assign pending = pending_q;

    generate
        if (DEPTH == 0) begin : g_nopipe
            assign dout       = active_q;
            assign dout_valid = event_q;
        end else begin : g_pipe
            logic [W-1:0]     data_q [DEPTH];
            logic [W-1:0]     data_d [DEPTH];
            logic [DEPTH-1:0] vld_q, vld_d;

            // The whole bank moves as one word, so dout never mixes updates.
            always_comb begin
                data_d[0] = active_q;
                vld_d[0]  = event_q;
                for (int k = 1; k < DEPTH; k++) begin
                    data_d[k] = data_q[k-1];
                    vld_d[k]  = vld_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k] <= RST_VEC;
                    end
                    vld_q <= '0;
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k] <= data_d[k];
                    end
                    vld_q <= vld_d;
                end
            end

            assign dout       = data_q[DEPTH-1];
            assign dout_valid = vld_q[DEPTH-1];
        end
    endgenerate

`ifdef REGISTER_BANK_UPDATE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + {15'd0, event_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign update_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (DEPTH=1 and DEPTH=3 instances).
// Counter checks are built when REGISTER_BANK_UPDATE_CNT_EN is defined.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ce;
    logic [63:0] din;
    logic        shadow_mode;
    logic        commit;

    logic [63:0] dout1, dout3;
    logic        valid1, valid3;
    logic [3:0]  pend1, pend3;
`ifdef REGISTER_BANK_UPDATE_CNT_EN
    logic [15:0] cnt1, cnt3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_bank #(.NBITS(16), .NCH(4), .DEPTH(1), .RESET_VAL(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .din(din),
        .shadow_mode(shadow_mode), .commit(commit),
        .dout(dout1), .dout_valid(valid1), .pending(pend1)
`ifdef REGISTER_BANK_UPDATE_CNT_EN
        , .update_cnt(cnt1)
`endif
    );

    register_bank #(.NBITS(16), .NCH(4), .DEPTH(3), .RESET_VAL(16'h0000)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .din(din),
        .shadow_mode(shadow_mode), .commit(commit),
        .dout(dout3), .dout_valid(valid3), .pending(pend3)
`ifdef REGISTER_BANK_UPDATE_CNT_EN
        , .update_cnt(cnt3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ce = '0;
        din = '0;
        shadow_mode = 1'b0;
        commit = 1'b0;
        tick();
        tick();
        check("rst_dout", dout1, 64'h0);
        check("rst_pending", {60'd0, pend1}, 64'h0);
        check("rst_valid", {63'd0, valid1}, 64'h0);
        check("rst_dout3", dout3, 64'h0);
`ifdef REGISTER_BANK_UPDATE_CNT_EN
        check("rst_cnt", {48'd0, cnt1}, 64'h0);
`endif
        rst = 1'b0;
        tick();

        // direct load ch0=1
        ce = 4'b0001;
        din = 64'h0000_0000_0000_0001;
        tick();
        ce = '0;
        check("direct_lat_dout", dout1, 64'h0);
        check("direct_lat_valid", {63'd0, valid1}, 64'h0);
        tick();
        check("direct_dout", dout1, 64'h0000_0000_0000_0001);
        check("direct_valid", {63'd0, valid1}, 64'h1);
        tick();
        check("direct_valid_off", {63'd0, valid1}, 64'h0);
        check("direct_hold", dout1, 64'h0000_0000_0000_0001);

        // shadow accumulate
        shadow_mode = 1'b1;
        ce = 4'b0001;
        din = 64'h0000_0000_0000_0002;
        tick();
        check("pend_ch0", {60'd0, pend1}, 64'h1);
        ce = 4'b1000;
        din = 64'hABCD_0000_0000_0000;
        tick();
        ce = '0;
        check("pend_1001", {60'd0, pend1}, 64'h9);
        tick();
        tick();
        check("shadow_dout_hold", dout1, 64'h0000_0000_0000_0001);
        check("shadow_no_valid", {63'd0, valid1}, 64'h0);

        // commit
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_pend_clr", {60'd0, pend1}, 64'h0);
        check("commit_pre_dout", dout1, 64'h0000_0000_0000_0001);
        tick();
        check("commit_dout", dout1, 64'hABCD_0000_0000_0002);
        check("commit_valid", {63'd0, valid1}, 64'h1);
        tick();
        check("commit_one_pulse", {63'd0, valid1}, 64'h0);

        // ce with commit on the same edge
        ce = 4'b0010;
        din = 64'h0000_0000_0005_0000;
        tick();
        check("bypass_pend_set", {60'd0, pend1}, 64'h2);
        din = 64'h0000_0000_0007_0000;
        commit = 1'b1;
        tick();
        ce = '0;
        commit = 1'b0;
        check("bypass_pend_clr", {60'd0, pend1}, 64'h0);
        tick();
        check("bypass_dout", dout1, 64'hABCD_0000_0007_0002);
        check("bypass_valid", {63'd0, valid1}, 64'h1);

        // mode switch discards pending shadow
        ce = 4'b0100;
        din = 64'h0000_0009_0000_0000;
        tick();
        ce = '0;
        check("discard_pend_set", {60'd0, pend1}, 64'h4);
        shadow_mode = 1'b0;
        tick();
        check("discard_pend_clr", {60'd0, pend1}, 64'h0);
        check("discard_valid_a", {63'd0, valid1}, 64'h0);
        tick();
        check("discard_dout", dout1, 64'hABCD_0000_0007_0002);
        check("discard_valid_b", {63'd0, valid1}, 64'h0);
        tick();
        tick();
        check("pipe_idle_valid", {63'd0, valid3}, 64'h0);
        check("pipe_idle_dout", dout3, 64'hABCD_0000_0007_0002);

        // DEPTH=3 back-to-back loads
        ce = 4'b0001;
        din = 64'h1;
        tick();
        din = 64'h2;
        tick();
        din = 64'h3;
        tick();
        ce = '0;
        check("pipe_lat_dout", dout3, 64'hABCD_0000_0007_0002);
        check("pipe_lat_valid", {63'd0, valid3}, 64'h0);
        tick();
        check("pipe_dout_1", dout3, 64'hABCD_0000_0007_0001);
        check("pipe_valid_1", {63'd0, valid3}, 64'h1);
        tick();
        check("pipe_dout_2", dout3, 64'hABCD_0000_0007_0002);
        check("pipe_valid_2", {63'd0, valid3}, 64'h1);
        tick();
        check("pipe_dout_3", dout3, 64'hABCD_0000_0007_0003);
        check("pipe_valid_3", {63'd0, valid3}, 64'h1);
        tick();
        check("pipe_valid_end", {63'd0, valid3}, 64'h0);

        // reset mid-pipeline
        ce = 4'b0001;
        din = 64'h4;
        tick();
        din = 64'h5;
        tick();
        ce = '0;
        rst = 1'b1;
        #1;
        check("midrst_dout", dout3, 64'h0);
        check("midrst_valid", {63'd0, valid3}, 64'h0);
        check("midrst_dout1", dout1, 64'h0);
        tick();
        check("midrst_hold_valid", {63'd0, valid3}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_valid_%0d", i), {63'd0, valid3}, 64'h0);
        end
        check("post_rst_dout", dout3, 64'h0);

`ifdef REGISTER_BANK_UPDATE_CNT_EN
        check("cnt_after_rst", {48'd0, cnt1}, 64'h0);
        ce = 4'b0001;
        din = 64'h1;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        ce = '0;
        check("cnt_ffff", {48'd0, cnt1}, 64'hFFFF);
        check("cnt3_ffff", {48'd0, cnt3}, 64'hFFFF);
        ce = 4'b0001;
        tick();
        ce = '0;
        check("cnt_wrap", {48'd0, cnt1}, 64'h0);
        tick();
        check("cnt_idle", {48'd0, cnt1}, 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Multi-channel, parametrised successor to the single clock-enabled register. It holds NCH independent NBITS-wide values. Each channel is loaded by its own clock enable, either directly or through a shadow stage that is committed atomically to all channels at once. A configurable output pipeline helps timing closure toward the DSP fabric. It sits between the AXI config/status registers and datapath blocks that need glitch-free, simultaneous multi-parameter updates.

## Interface
- NBITS, 16, width of one channel
- NCH, 4, number of channels (1..32)
- DEPTH, 1, output pipeline stages (0..8)
- RESET_VAL, 0, NBITS-wide reset value of every channel
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- ce  in  NCH  per-channel load enable; bit i loads channel i
- din  in  NCH*NBITS  channel i data at bits [i*NBITS +: NBITS]
- shadow_mode  in  1  0: direct load; 1: double-buffered load
- commit  in  1  single-cycle pulse; transfers all shadows to active (shadow_mode=1 only)
- dout  out  NCH*NBITS  pipelined active values, same packing as din
- dout_valid  out  1  one-cycle pulse marking the first cycle dout shows a new update
- pending  out  NCH  bit i set: shadow i written but not yet committed

## Operation
- Storage: shadow[i] and active[i], NBITS each, per channel.
- On ce[i]: shadow[i] <= din slice i, in both modes.
- Direct mode (shadow_mode=0): on ce[i], active[i] <= din slice i in the same edge. commit is ignored. pending is held at 0.
- Shadow mode (shadow_mode=1):
  - ce[i] alone: updates shadow[i] and sets pending[i]; active[i] is unchanged.
  - commit: active[j] <= shadow[j] for all j, and all pending bits clear.
  - ce[i] and commit on the same edge: active[i] takes the new din slice (bypass). pending[i] is cleared. Other channels take their shadow values.
  - commit with pending all 0: active reloads identical values; still counts as an update.
- Mode switch 1->0 with pending bits set: the pending bits clear on the next edge and the uncommitted shadows are discarded, so active is unchanged. Mode switch 0->1: no effect until the next ce.
- Update event: in direct mode, any ce bit high; in shadow mode, commit high. The event flag travels with the data through the pipeline.
- Output pipeline: DEPTH register stages carry {active, event}. dout is the last stage and dout_valid is the last stage's event bit. With DEPTH=0, dout is wired to active and dout_valid is the registered event flag.
- No backpressure. Updates on consecutive edges each produce their own dout_valid pulse.

## Timing
- Reset (asynchronous assert, synchronous release):
  - shadow, active and every pipeline stage = RESET_VAL.
  - pending = 0, dout_valid = 0, update_cnt = 0.
  - In-flight pipeline updates are dropped, with no dout_valid pulse.
- Latency: din sampled at edge n (ce high, or commit in shadow mode) appears on dout after edge n+DEPTH. dout_valid is high for exactly the cycle after edge n+DEPTH.
- pending[i] updates at the same edge as the ce[i] that sets it, with no pipeline delay.
- Throughput: one update per clock. dout never shows a mix of pre- and post-commit channel values.

## Configuration
- REGISTER_BANK_UPDATE_CNT_EN defined: adds the output update_cnt (16 bits).
  - It increments by 1 on each update event at the active stage, wrapping 0xFFFF -> 0x0000.
  - It is not delayed by DEPTH.
  - It is readable by software for detecting missed updates.
- REGISTER_BANK_UPDATE_CNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset and direct load, DEPTH=1, NCH=4:
  - rst high: dout=0, pending=0.
  - shadow_mode=0, ce=4'b0001 with ch0=1 at edge n: dout ch0=1 after edge n+1, dout_valid high one cycle, other channels 0.
- Shadow accumulate and commit:
  - shadow_mode=1, load ch0=2 then ch3=0xABCD on separate edges: pending=4'b1001 and dout unchanged.
  - Pulse commit: both values appear on the same cycle, pending=0, exactly one dout_valid pulse.
- Simultaneous ce and commit:
  - shadow ch1=5 pending; ce[1] with din ch1=7 together with commit.
  - Required: dout ch1=7 and pending[1]=0.
- Mode switch discard:
  - shadow ch2=9 pending, then shadow_mode->0 with no commit.
  - Required: pending clears next edge, dout ch2 keeps its old value, no dout_valid.
- Pipeline and reset:
  - DEPTH=3: back-to-back direct loads 1,2,3 on ch0 give three consecutive dout_valid pulses with dout=1,2,3.
  - Assert rst mid-pipeline: dout returns to RESET_VAL immediately, with no further pulses.
- Counter (REGISTER_BANK_UPDATE_CNT_EN defined):
  - Preload by 65535 direct updates: update_cnt=0xFFFF.
  - One more update: update_cnt=0x0000.
